// File: rtl/rr_arbiter16.sv
// rr_arbiter16: 16-way round-robin arbiter that grants exclusive ownership of a shared 16:1 mux path.
// Optional feature: define ARB_TIMEOUT_EN to force a release after HOLD_MAX owned cycles (tmo pulse).
module rr_arbiter16 #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] grant,
  output logic [3:0]  sel,
  output logic        busy,
  output logic        tmo
);

  typedef enum logic {StIdle = 1'b0, StOwn = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [3:0]  sel_q, sel_d;
  logic [15:0] grant_q, grant_d;

  logic        win_found;
  logic [3:0]  win_idx;
  logic [3:0]  scan_idx;
  logic        owner_release;
  logic        force_release;

  if ((HOLD_MAX == 0) || (HOLD_MAX > 255)) begin : g_hold_max_check
    $error("rr_arbiter16: HOLD_MAX must be within 1..255");
  end

  // In OWN, sel_q always holds the current owner's index.
  assign owner_release = done || !req[sel_q];

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       tmo_q, tmo_d;

  // A simultaneous voluntary release takes precedence and is not reported as a timeout.
  assign force_release = (state_q == StOwn) && !owner_release && (cnt_q == HoldLast);

  always_comb begin
    cnt_d = '0;
    tmo_d = force_release;
    if (state_q == StOwn) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign tmo = tmo_q;
`else
  assign force_release = 1'b0;
  assign tmo           = 1'b0;
`endif

  // First requester at or above ptr, wrapping 15 -> 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    scan_idx  = ptr_q;
    for (int i = 0; i < 16; i++) begin
      scan_idx = ptr_q + 4'(i);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StOwn;
          sel_d   = win_idx;
          grant_d = 16'(1) << win_idx;
        end
      end
      StOwn: begin
        if (owner_release || force_release) begin
          state_d = StIdle;
          grant_d = '0;
          ptr_d   = sel_q + 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign busy  = |grant_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Self-checking bench for rr_arbiter16: directed scenarios plus random traffic against an
// owner/pointer reference model.
module tb_rr_arbiter16;

  localparam int unsigned HoldMax = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic [15:0] grant;
  logic [3:0]  sel;
  logic        busy;
  logic        tmo;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: owner index (-1 when nobody owns the path), next search start, last owner.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_sel   = 0;
  int m_hold  = 0;
  bit m_tmo   = 1'b0;

  rr_arbiter16 #(.HOLD_MAX(HoldMax)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .done  (done),
    .grant (grant),
    .sel   (sel),
    .busy  (busy),
    .tmo   (tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic [15:0] rq, input logic d);
    bit rel;
    bit expired;
    if (r) begin
      m_owner = -1;
      m_ptr   = 0;
      m_sel   = 0;
      m_hold  = 0;
      m_tmo   = 1'b0;
    end else if (m_owner < 0) begin
      m_tmo = 1'b0;
      for (int k = 0; k < 16; k++) begin
        if (m_owner < 0 && rq[(m_ptr + k) % 16]) begin
          m_owner = (m_ptr + k) % 16;
          m_sel   = m_owner;
          m_hold  = 0;
        end
      end
    end else begin
      rel     = d || !rq[m_owner];
      m_hold  = m_hold + 1;
`ifdef ARB_TIMEOUT_EN
      expired = (m_hold >= int'(HoldMax));
`else
      expired = 1'b0;
`endif
      m_tmo = 1'b0;
      if (rel || expired) begin
        m_tmo   = !rel && expired;
        m_ptr   = (m_owner + 1) % 16;
        m_owner = -1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    chk({tag, "_grant"}, 32'(grant), 32'(eg));
    chk({tag, "_sel"}, 32'(sel), 32'(m_sel));
    chk({tag, "_busy"}, 32'(busy), 32'(m_owner >= 0));
    chk({tag, "_tmo"}, 32'(tmo), 32'(m_tmo));
  endtask

  task automatic step(input string tag, input logic r, input logic [15:0] rq, input logic d);
    rst  = r;
    req  = rq;
    done = d;
    @(posedge clk);
    model_update(r, rq, d);
    #1;
    check_all(tag);
  endtask

  initial begin
    int          next_owner;
    int          held;
    logic [15:0] rq;
    logic        dn;
    logic        rs;

    // Reset, then an idle bus.
    step("rst", 1'b1, 16'h0000, 1'b0);
    step("rst", 1'b1, 16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step("idle", 1'b0, 16'h0000, 1'b0);
      chk("idle_grant_zero", 32'(grant), 32'h0);
      chk("idle_sel_zero", 32'(sel), 32'h0);
    end

    // Two requesters at the wrap boundary.
    step("w_a", 1'b0, 16'h8001, 1'b0);
    chk("wrap_first_grant", 32'(grant), 32'h0001);
    step("w_b", 1'b0, 16'h8001, 1'b1);
    chk("wrap_release_gap", 32'(busy), 32'h0);
    step("w_c", 1'b0, 16'h8001, 1'b0);
    chk("wrap_second_grant", 32'(grant), 32'h8000);
    chk("wrap_second_sel", 32'(sel), 32'hf);
    step("w_d", 1'b0, 16'h8001, 1'b1);
    chk("wrap_sel_kept", 32'(sel), 32'hf);
    step("w_e", 1'b0, 16'h8001, 1'b0);
    chk("wrap_ptr_to_zero", 32'(grant), 32'h0001);
    step("w_f", 1'b0, 16'h0000, 1'b0);

    // Full rotation with done every cycle: owners alternate with idle cycles.
    step("rr_rst", 1'b1, 16'h0000, 1'b0);
    next_owner = 0;
    for (int i = 0; i < 34; i++) begin
      step("rr", 1'b0, 16'hffff, 1'b1);
      if (busy) begin
        chk("rr_order", 32'(sel), 32'(next_owner % 16));
        next_owner++;
      end
    end
    chk("rr_count", 32'(next_owner), 32'd17);

    // Owner drops its request while another is pending.
    step("drop_rst", 1'b1, 16'h0000, 1'b0);
    step("drop_a", 1'b0, 16'h0088 & 16'h0008, 1'b0);
    chk("drop_owner3", 32'(grant), 32'h0008);
    step("drop_b", 1'b0, 16'h0080, 1'b0);
    chk("drop_released", 32'(grant), 32'h0);
    step("drop_c", 1'b0, 16'h0080, 1'b0);
    chk("drop_owner7", 32'(grant), 32'h0080);
    chk("drop_sel7", 32'(sel), 32'h7);

    // Reset in the middle of ownership.
    step("mr_a", 1'b0, 16'h0000, 1'b1);
    step("mr_b", 1'b1, 16'h0000, 1'b0);
    step("mr_c", 1'b0, 16'h0020, 1'b0);
    chk("mr_owner5", 32'(grant), 32'h0020);
    step("mr_d", 1'b1, 16'h0020, 1'b0);
    chk("mr_grant_drop", 32'(grant), 32'h0);
    chk("mr_sel_zero", 32'(sel), 32'h0);
    step("mr_e", 1'b0, 16'h0020, 1'b0);
    chk("mr_regrant", 32'(grant), 32'h0020);

    // Long hold without done: timeout build releases every HoldMax cycles, default holds on.
    step("hold_rst", 1'b1, 16'h0000, 1'b0);
    held = 0;
    for (int i = 0; i < 110; i++) begin
      step("hold", 1'b0, 16'h0004, 1'b0);
      if (grant == 16'h0004) held++;
    end
`ifdef ARB_TIMEOUT_EN
    chk("hold_bounded", 32'(held < 110), 32'h1);
`else
    chk("hold_forever", 32'(held), 32'd110);
`endif

    // Random traffic; requests persist for a while so owners hold across several cycles.
    rq = 16'(($urandom & $urandom));
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(3, 0) == 0) rq = 16'(($urandom & $urandom));
      dn = ($urandom_range(4, 0) == 0);
      rs = ($urandom_range(59, 0) == 0);
      step("rnd", rs, rq, dn);
      chk("rnd_onehot", 32'($countones(grant) <= 1), 32'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter16.md
RR_ARBITER16 -- requirements
Module: rr_arbiter16

Interface
REQ-001 Parameter HOLD_MAX, default 16: maximum grant-hold cycles before forced release; used only when ARB_TIMEOUT_EN is defined; legal range 1..255.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  16  request vector; req[i]=1 means requester i wants the shared 16:1 mux path.
REQ-005 done  input  1  current owner releases the path this cycle.
REQ-006 grant  output  16  one-hot grant; all-zero when no owner.
REQ-007 sel  output  4  binary index of current or most recent owner; drives the shared mux select.
REQ-008 busy  output  1  high while any grant is asserted.
REQ-009 tmo  output  1  one-cycle pulse on forced release (timeout); constant 0 when ARB_TIMEOUT_EN is undefined.

Function
REQ-010 The block SHALL implement a two-state FSM, IDLE and OWN, with a 4-bit round-robin pointer ptr.
REQ-011 In IDLE with req==0, the block SHALL stay in IDLE with grant=0, busy=0, and sel unchanged.
REQ-012 In IDLE with req!=0, the winner SHALL be the first set bit at or above ptr, searching upward and wrapping from 15 to 0.
REQ-013 The winner's grant bit, sel=winner, and busy=1 SHALL be registered at the next edge, and the FSM SHALL enter OWN; request-to-grant latency is exactly 1 cycle.
REQ-014 In OWN, grant and sel SHALL hold steady regardless of changes on other req bits.
REQ-015 In OWN, if done=1 or req[owner]=0, the block SHALL release at the next edge: grant=0, busy=0, ptr=(owner+1) mod 16, return to IDLE; sel keeps owner's index.
REQ-016 Every release SHALL be followed by at least one IDLE cycle, so back-to-back owners are separated by one non-granted cycle.
REQ-017 done asserted in IDLE SHALL be ignored.
REQ-018 If done and new requests arrive in the same OWN cycle, release SHALL take effect first; arbitration SHALL occur in the following IDLE cycle using the updated ptr.
REQ-019 ptr arithmetic SHALL be modulo 16 (owner 15 gives ptr=0).
REQ-020 grant SHALL never have more than one bit set, and busy SHALL always equal |grant.

Reset
REQ-021 When rst=1 at a rising edge, the block SHALL set state=IDLE, ptr=0, grant=0, sel=0, busy=0, tmo=0, and hold counter=0.
REQ-022 rst SHALL take priority over all other inputs, including during OWN; an active grant SHALL drop at that edge.
REQ-023 On the first edge after rst deasserts, arbitration SHALL start from ptr=0.

Configuration
REQ-024 Macro ARB_TIMEOUT_EN defined: an 8-bit hold counter SHALL clear on entry to OWN and increment each OWN cycle.
REQ-025 Macro ARB_TIMEOUT_EN defined: when the owner has held the grant for HOLD_MAX cycles without releasing, the block SHALL force a release per REQ-015 and pulse tmo=1 for that one cycle.
REQ-026 Macro ARB_TIMEOUT_EN undefined: no counter SHALL be synthesized, tmo SHALL be tied to 0, and the grant SHALL be held indefinitely until done or the owner's req drops.

Verification
REQ-027 Reset then req=16'h0000 for 5 cycles -> grant=0, busy=0, sel=0 throughout.
REQ-028 req=16'h8001 after reset -> grant=16'h0001, sel=0 next cycle; pulse done -> 1 IDLE cycle -> grant=16'h8000, sel=15; done -> ptr wraps to 0 and bit 0 wins again.
REQ-029 All 16 req held high, done pulsed every owner cycle -> grant order 0,1,...,15,0, each grant separated by one idle cycle.
REQ-030 Owner 3 granted, req[3] drops while req[7]=1 -> release next edge, then grant=16'h0080, sel=7.
REQ-031 Owner 5 granted, rst=1 for one cycle -> grant=0, busy=0, sel=0 at that edge; req[5] still high -> grant bit 5 one cycle after rst falls.
REQ-032 ARB_TIMEOUT_EN defined, HOLD_MAX=4, req[2] held high, no done -> grant bit 2 held 4 cycles, then forced release with tmo=1 for one cycle and ptr=3; without the macro, grant is held for 100+ cycles and tmo=0.
